psum_pkt_arbiter: RTL and testbench
===================================

Name: psum_pkt_arbiter

Overview:
- Shares one partial-sum packet injection point among N_REQ adder result sources.
- Each source offers a DWIDTH-bit partial sum. The block picks one source round-robin and wraps the sum into a PWIDTH-bit NoC packet.
- Packets are issued to the router under credit-based flow control.
- Sits between the adder array and the NoC router port; replaces per-adder packetizers.

Parameters:
- N_REQ, 4, number of partial-sum requesters (2..8).
- DWIDTH, 8, partial-sum width.
- PWIDTH, 47, packet width; must equal 1+3+3+PAD_W+DWIDTH.
- PAD_W, 32, filler field width.
- PAD_VAL, 32'h0000FFFF, filler field value.
- TYPE_BIT, 1'b1, packet type (1 = psum/ifm class).
- DEST_ADDR, 3'b110, destination node address.
- SRC_BASE, 3'b100, source address of requester 0; requester i uses SRC_BASE+i, modulo 8.
- CREDITS, 2, downstream buffer depth (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  per-requester partial sum valid.
- req_data  in  N_REQ*DWIDTH  packed partial sums; requester i uses bits [i*DWIDTH +: DWIDTH].
- req_ready  out  N_REQ  one-hot accept pulse.
- out_valid  out  1  packet valid.
- out_packet  out  PWIDTH  packet.
- out_ready  in  1  router accepts the packet.
- credit_in  in  1  one-cycle pulse; the router freed one buffer slot.
- credit_cnt  out  3  current credits.
- credit_err  out  1  sticky flag: a credit was returned while at CREDITS.

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - state=IDLE, out_valid=0, out_packet=0, req_ready=0.
  - rr_ptr=0, credit_cnt=CREDITS, credit_err=0.
  - Reset mid-packet drops the held packet. No handshake completes in a reset cycle.
- State machine with states IDLE and HOLD.
- IDLE:
  - Grant happens when any req_valid=1 and credit_cnt>0.
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - req_ready[winner]=1 combinationally in that same cycle. At most one bit of req_ready is ever high.
  - At the clock edge of the grant:
    - out_packet <= {TYPE_BIT, DEST_ADDR, SRC_BASE+winner, PAD_VAL, req_data[winner]}.
    - out_valid <= 1.
    - rr_ptr <= (winner+1) mod N_REQ.
    - state <= HOLD.
  - With no valid request or credit_cnt=0: req_ready=0 and the state stays IDLE.
- HOLD:
  - out_valid=1; out_packet is held stable.
  - out_ready=1 completes the handshake: out_valid <= 0, state <= IDLE, credit is consumed.
  - out_ready=0: stay in HOLD. req_ready=0 throughout HOLD.
- Latency and throughput:
  - Request accepted in cycle n gives out_valid=1 in cycle n+1.
  - Maximum throughput is one packet per 2 cycles.
- Credits:
  - Handshake without credit_in: credit_cnt-1.
  - credit_in without handshake: credit_cnt+1.
  - Both in the same cycle: unchanged.
  - credit_in while credit_cnt=CREDITS with no handshake: count saturates and credit_err <= 1 (sticky until rst).
  - credit_cnt never underflows, because grants need credit_cnt>0.
- Requesters keep req_valid and req_data stable until they see req_ready. Dropping req_valid before grant is legal and simply withdraws the request.
- rr_ptr does not advance when no grant occurs.

Test Plan:
- Reset check: assert rst 2 cycles -> out_valid=0, req_ready=0, credit_cnt=2, credit_err=0.
- Single request: req_valid=4'b0001, req_data[0]=8'h2A, out_ready=1.
  - req_ready=4'b0001 in the request cycle.
  - Next cycle out_packet = {1'b1, 3'b110, 3'b100, 32'h0000FFFF, 8'h2A} and out_valid=1.
  - credit_cnt drops to 1 after the handshake.
- Round-robin fairness: all four valid continuously, out_ready=1, credit_in pulsed after each packet.
  - Grant order 0,1,2,3,0.
  - Source fields 100, 101, 110, 111, 100.
- Credit stall: no credit_in, three requests pending.
  - Two packets issue, then credit_cnt=0 and req_ready stays 0.
  - One credit_in pulse produces exactly one more grant.
- Backpressure: out_ready=0 for 5 cycles in HOLD.
  - out_packet stays stable, req_ready=0, credit_cnt unchanged.
  - Setting out_ready=1 completes the handshake; the block is back in IDLE the next cycle.
- Edge cases:
  - credit_in coinciding with a handshake leaves credit_cnt unchanged.
  - credit_in at credit_cnt=2 sets credit_err=1.
  - rst in HOLD clears out_valid the next cycle, and the packet is never delivered.

Source files
------------

// File: rtl/psum_pkt_arbiter.sv
// Round-robin arbiter that packs one partial sum at a time into a NoC packet
// and issues it to the router under credit-based flow control.
module psum_pkt_arbiter #(
    parameter int                N_REQ     = 4,
    parameter int                DWIDTH    = 8,
    parameter int                PWIDTH    = 47,
    parameter int                PAD_W     = 32,
    parameter logic [PAD_W-1:0]  PAD_VAL   = 32'h0000FFFF,
    parameter logic              TYPE_BIT  = 1'b1,
    parameter logic [2:0]        DEST_ADDR = 3'b110,
    parameter logic [2:0]        SRC_BASE  = 3'b100,
    parameter int                CREDITS   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DWIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      out_valid,
    output logic [PWIDTH-1:0]         out_packet,
    input  logic                      out_ready,
    input  logic                      credit_in,
    output logic [2:0]                credit_cnt,
    output logic                      credit_err
);

    localparam int unsigned NR       = N_REQ;
    localparam int          PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [2:0]  CRED_MAX = 3'(CREDITS);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PWIDTH-1:0]   pkt_q, pkt_d;
    logic                valid_q, valid_d;
    logic [2:0]          cred_q, cred_d;
    logic                err_q, err_d;

    logic                found;
    logic [PTR_W-1:0]    winner;
    logic [DWIDTH-1:0]   win_data;
    logic                grant;
    logic                handshake;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr_q) + k) % NR;
            if (!found && req_valid[PTR_W'(idx)]) begin
                found    = 1'b1;
                winner   = PTR_W'(idx);
                win_data = req_data[idx*DWIDTH +: DWIDTH];
            end
        end
    end

    assign grant     = !rst && (state_q == IDLE) && found && (cred_q != 3'd0);
    assign handshake = !rst && (state_q == HOLD) && out_ready;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_d     = pkt_q;
        valid_d   = valid_q;
        cred_d    = cred_q;
        err_d     = err_q;
        req_ready = '0;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    req_ready[winner] = 1'b1;
                    pkt_d    = PWIDTH'({TYPE_BIT, DEST_ADDR, SRC_BASE + 3'(winner),
                                        PAD_VAL, win_data});
                    valid_d  = 1'b1;
                    rr_ptr_d = (32'(winner) == NR - 1) ? '0 : winner + 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A returned credit and a consumed credit in the same cycle cancel out.
        if (handshake && !credit_in) begin
            cred_d = cred_q - 3'd1;
        end else if (credit_in && !handshake) begin
            if (cred_q == CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                cred_d = cred_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            pkt_q    <= '0;
            valid_q  <= 1'b0;
            cred_q   <= CRED_MAX;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            pkt_q    <= pkt_d;
            valid_q  <= valid_d;
            cred_q   <= cred_d;
            err_q    <= err_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_packet = pkt_q;
    assign credit_cnt = cred_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_psum_pkt_arbiter.sv
// Bench for psum_pkt_arbiter: directed vector table, hand-written multi-cycle
// sequences, then random traffic against a behavioural model.
module tb_psum_pkt_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [46:0] out_packet;
    logic        out_ready;
    logic        credit_in;
    logic [2:0]  credit_cnt;
    logic        credit_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    psum_pkt_arbiter #(
        .N_REQ    (4),
        .DWIDTH   (8),
        .PWIDTH   (47),
        .PAD_W    (32),
        .PAD_VAL  (32'h0000FFFF),
        .TYPE_BIT (1'b1),
        .DEST_ADDR(3'b110),
        .SRC_BASE (3'b100),
        .CREDITS  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_packet(out_packet),
        .out_ready (out_ready),
        .credit_in (credit_in),
        .credit_cnt(credit_cnt),
        .credit_err(credit_err)
    );

    function automatic logic [46:0] mkpkt(int src, logic [7:0] d);
        logic [2:0] s;
        s = 3'(src % 8);
        return {1'b1, 3'b110, s, 32'h0000FFFF, d};
    endfunction

    // ---------------- behavioural reference model ----------------
    int          m_ptr  = 0;
    int          m_cred = 2;
    bit          m_hold = 0;
    bit          m_err  = 0;
    logic [46:0] m_pkt  = '0;

    function automatic int m_win(logic [3:0] rv, bit r);
        if (r || m_hold || m_cred == 0) return -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (rv[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_pick(logic [3:0] rv, bit r);
        int w;
        logic [3:0] one;
        w = m_win(rv, r);
        one = 4'b0001;
        return (w < 0) ? 4'b0000 : (one << w);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ptr  <= 0;
            m_cred <= 2;
            m_hold <= 0;
            m_err  <= 0;
            m_pkt  <= '0;
        end else begin
            if (m_win(req_valid, rst) >= 0) begin
                m_hold <= 1;
                m_pkt  <= mkpkt(4 + m_win(req_valid, rst), req_data[m_win(req_valid, rst)*8 +: 8]);
                m_ptr  <= (m_win(req_valid, rst) + 1) % 4;
            end else if (m_hold && out_ready) begin
                m_hold <= 0;
            end
            if (credit_in && !(m_hold && out_ready) && m_cred == 2)
                m_err <= 1;
            else
                m_cred <= m_cred + int'(credit_in) - int'(m_hold && out_ready);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(bit r, logic [3:0] rv, logic [31:0] rd, bit ordy, bit ci);
        rst       = r;
        req_valid = rv;
        req_data  = rd;
        out_ready = ordy;
        credit_in = ci;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         chk;
        bit         rst;
        logic [3:0] rv;
        bit         ordy;
        bit         ci;
        logic [3:0] e_rr;
        bit         e_ov;
        logic [2:0] e_cc;
        bit         e_err;
        int         e_src;
        logic [7:0] e_dat;
    } vec_t;

    function automatic vec_t mk(bit c, bit r, logic [3:0] rv, bit o, bit ci,
                                logic [3:0] err_rr, bit ov, logic [2:0] cc, bit er,
                                int src, logic [7:0] dat);
        vec_t v;
        v.chk = c;  v.rst = r;  v.rv = rv;  v.ordy = o;  v.ci = ci;
        v.e_rr = err_rr;  v.e_ov = ov;  v.e_cc = cc;  v.e_err = er;
        v.e_src = src;  v.e_dat = dat;
        return v;
    endfunction

    localparam logic [31:0] DWORD = 32'h4433_112A;

    vec_t tv[$];
    logic [3:0]  pend;
    logic [31:0] pdata;
    logic [3:0]  last_g;
    logic [3:0]  one;

    initial begin
        // Directed table: each row is one cycle's inputs and the outputs seen in it.
        tv.push_back(mk(0,1,4'b0000,0,0, 4'b0000,0,2,0, 0,8'h00));
        tv.push_back(mk(1,1,4'b0000,0,0, 4'b0000,0,2,0, 0,8'h00));
        tv.push_back(mk(1,0,4'b0001,1,0, 4'b0001,0,2,0, 0,8'h00));
        tv.push_back(mk(1,0,4'b0000,1,0, 4'b0000,1,2,0, 4,8'h2A));
        tv.push_back(mk(1,0,4'b0000,1,0, 4'b0000,0,1,0, 0,8'h00));
        tv.push_back(mk(1,0,4'b0010,1,0, 4'b0010,0,1,0, 0,8'h00));
        tv.push_back(mk(1,0,4'b0000,1,1, 4'b0000,1,1,0, 5,8'h11));
        tv.push_back(mk(1,0,4'b0000,0,1, 4'b0000,0,1,0, 0,8'h00));
        tv.push_back(mk(1,0,4'b0000,0,1, 4'b0000,0,2,0, 0,8'h00));
        tv.push_back(mk(1,0,4'b0100,0,0, 4'b0100,0,2,1, 0,8'h00));
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(1,0,4'b0000,0,0, 4'b0000,1,2,1, 6,8'h33));
        tv.push_back(mk(1,0,4'b0000,1,0, 4'b0000,1,2,1, 6,8'h33));
        tv.push_back(mk(1,0,4'b0000,1,0, 4'b0000,0,1,1, 0,8'h00));
        tv.push_back(mk(1,0,4'b1000,0,0, 4'b1000,0,1,1, 0,8'h00));
        tv.push_back(mk(1,1,4'b0000,1,0, 4'b0000,1,1,1, 7,8'h44));
        tv.push_back(mk(1,0,4'b0000,1,0, 4'b0000,0,2,0, 0,8'h00));
        tv.push_back(mk(1,0,4'b0000,1,0, 4'b0000,0,2,0, 0,8'h00));

        @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].rv, DWORD, tv[i].ordy, tv[i].ci);
            if (tv[i].chk) begin
                chk($sformatf("tbl%0d req_ready", i), 64'(req_ready), 64'(tv[i].e_rr));
                chk($sformatf("tbl%0d out_valid", i), 64'(out_valid), 64'(tv[i].e_ov));
                chk($sformatf("tbl%0d credit_cnt", i), 64'(credit_cnt), 64'(tv[i].e_cc));
                chk($sformatf("tbl%0d credit_err", i), 64'(credit_err), 64'(tv[i].e_err));
                if (tv[i].e_ov)
                    chk($sformatf("tbl%0d out_packet", i), 64'(out_packet),
                        64'(mkpkt(tv[i].e_src, tv[i].e_dat)));
            end
            tick();
        end

        // Round-robin fairness: all four requesting, credit returned with each handshake.
        one = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            drive(0, 4'b1111, DWORD, 1, 0);
            chk($sformatf("rr%0d grant", k), 64'(req_ready), 64'(one << (k % 4)));
            tick();
            drive(0, 4'b1111, DWORD, 1, 1);
            chk($sformatf("rr%0d hold_ready", k), 64'(req_ready), 64'(0));
            chk($sformatf("rr%0d packet", k), 64'(out_packet),
                64'(mkpkt(4 + (k % 4), 8'(DWORD >> (8 * (k % 4))))));
            chk($sformatf("rr%0d credit", k), 64'(credit_cnt), 64'(2));
            tick();
        end

        // Credit stall: no credit returned, three requesters pending.
        drive(1, 4'b0000, DWORD, 0, 0); tick(); tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 4'b0111, DWORD, 1, 0);
            chk($sformatf("stall grant%0d", k), 64'(req_ready), 64'(one << k));
            tick();
            drive(0, 4'b0111, DWORD, 1, 0);
            chk($sformatf("stall src%0d", k), 64'(out_packet), 64'(mkpkt(4 + k, 8'(DWORD >> (8 * k)))));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 4'b0111, DWORD, 1, 0);
            chk($sformatf("stall blocked%0d", k), 64'(req_ready), 64'(0));
            chk($sformatf("stall cc%0d", k), 64'(credit_cnt), 64'(0));
            tick();
        end
        drive(0, 4'b0111, DWORD, 1, 1);
        chk("stall pulse_cycle", 64'(req_ready), 64'(0));
        tick();
        drive(0, 4'b0111, DWORD, 1, 0);
        chk("stall regrant", 64'(req_ready), 64'(4'b0100));
        tick();
        drive(0, 4'b0111, DWORD, 1, 0);
        chk("stall regrant_pkt", 64'(out_packet), 64'(mkpkt(6, 8'h33)));
        tick();
        drive(0, 4'b0111, DWORD, 1, 0);
        chk("stall exhausted", 64'(req_ready), 64'(0));
        chk("stall exhausted_cc", 64'(credit_cnt), 64'(0));
        tick();

        // Random traffic against the model.
        drive(1, 4'b0000, DWORD, 0, 0); tick(); tick();
        pend   = '0;
        pdata  = '0;
        last_g = '0;
        for (int c = 0; c < 600; c++) begin
            logic [3:0] eg;
            pend = pend & ~last_g;
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    pdata[i*8 +: 8] = 8'($urandom);
                end else if (pend[i] && ($urandom % 25 == 0)) begin
                    pend[i] = 1'b0;
                end
            end
            drive(($urandom % 150) == 0, pend, pdata, ($urandom % 4) != 0, ($urandom % 5) == 0);
            eg = m_pick(req_valid, rst);
            chk("rnd req_ready", 64'(req_ready), 64'(eg));
            chk("rnd out_valid", 64'(out_valid), 64'(m_hold));
            if (m_hold)
                chk("rnd out_packet", 64'(out_packet), 64'(m_pkt));
            chk("rnd credit_cnt", 64'(credit_cnt), 64'(3'(m_cred)));
            chk("rnd credit_err", 64'(credit_err), 64'(m_err));
            last_g = eg;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
